// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and state encoding for the SDF butterfly
package fft_pkg;

   localparam int DW_DEF    = 32;
   localparam int SHIFT_DEF = 16;
   localparam int PW        = 65;

   typedef enum logic {
      FILL = 1'b0,
      BFLY = 1'b1
   } state_e;

endpackage

// File: rtl/fft_scale_sat.sv
// rtl/fft_scale_sat.sv - round, arithmetic-shift and reduce one product component (FFT_SAT_EN selects clamp)
module fft_scale_sat
   import fft_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int SHIFT = SHIFT_DEF
) (
   input  logic [PW-1:0] x_i,
   output logic [DW-1:0] s_o
);

   // One extra bit keeps the rounding add from overflowing at the top of the range.
   localparam logic signed [PW:0] HALF = {{PW{1'b0}}, 1'b1} << (SHIFT - 1);

   logic signed [PW:0] rnd;
   logic signed [PW:0] shf;

   assign rnd = $signed({x_i[PW-1], x_i}) + HALF;
   assign shf = rnd >>> SHIFT;

`ifdef FFT_SAT_EN
   localparam logic signed [PW:0] MAXV = {{(PW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
   localparam logic signed [PW:0] MINV = ~MAXV;

   // Clamp out-of-range values to the nearest representable DW-bit bound.
   always_comb begin
      s_o = shf[DW-1:0];
      if (shf > MAXV) begin
         s_o = {1'b0, {(DW - 1){1'b1}}};
      end else if (shf < MINV) begin
         s_o = {1'b1, {(DW - 1){1'b0}}};
      end
   end
`else
   logic unused_hi;

   assign s_o       = shf[DW-1:0];
   assign unused_hi = ^shf[PW:DW];
`endif

endmodule

// File: rtl/fft_sdf_bfly.sv
// rtl/fft_sdf_bfly.sv - single-delay-feedback radix-2 butterfly (FFT_SAT_EN enables scaled-value clamping)
module fft_sdf_bfly
   import fft_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int N_DELAY = 4,
   parameter int SHIFT   = SHIFT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [PW-1:0] in_real,
   input  logic [PW-1:0] in_imag,
   output logic          out_valid,
   output logic [DW:0]   out_real,
   output logic [DW:0]   out_imag
);

   localparam int            CW        = (N_DELAY > 1) ? $clog2(2 * N_DELAY) : 1;
   localparam logic [CW-1:0] LAST_FILL = CW'(N_DELAY - 1);
   localparam logic [CW-1:0] LAST      = CW'(2 * N_DELAY - 1);

   logic [DW-1:0] s_re, s_im;
   logic [DW:0]   b_re, b_im;
   logic [DW:0]   head_re, head_im;
   logic [DW:0]   ent_re, ent_im;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          out_valid_q, out_valid_d;
   logic [DW:0]   out_real_q, out_real_d;
   logic [DW:0]   out_imag_q, out_imag_d;

   logic [DW:0]   dl_re_q [N_DELAY];
   logic [DW:0]   dl_im_q [N_DELAY];

   fft_scale_sat #(.DW(DW), .SHIFT(SHIFT)) u_scale_re (.x_i(in_real), .s_o(s_re));
   fft_scale_sat #(.DW(DW), .SHIFT(SHIFT)) u_scale_im (.x_i(in_imag), .s_o(s_im));

   assign b_re    = {s_re[DW-1], s_re};
   assign b_im    = {s_im[DW-1], s_im};
   assign head_re = dl_re_q[N_DELAY-1];
   assign head_im = dl_im_q[N_DELAY-1];

   // Next-state: frame counter, phase, pending flag, output register and delay-line entry.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      out_valid_d = 1'b0;
      out_real_d  = out_real_q;
      out_imag_d  = out_imag_q;
      ent_re      = b_re;
      ent_im      = b_im;
      if (in_valid) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
         case (state_q)
            FILL: begin
               // Head holds the previous frame's differences; stale until one frame completes.
               out_valid_d = pend_q;
               if (pend_q) begin
                  out_real_d = head_re;
                  out_imag_d = head_im;
               end
               if (cnt_q == LAST_FILL) state_d = BFLY;
            end
            BFLY: begin
               out_valid_d = 1'b1;
               out_real_d  = head_re + b_re;
               out_imag_d  = head_im + b_im;
               ent_re      = head_re - b_re;
               ent_im      = head_im - b_im;
               if (cnt_q == LAST) begin
                  state_d = FILL;
                  pend_d  = 1'b1;
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_real_q  <= '0;
         out_imag_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         out_real_q  <= out_real_d;
         out_imag_q  <= out_imag_d;
      end
   end

   // Delay line shifts only on accepted samples; its contents are never reset.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         dl_re_q[0] <= ent_re;
         dl_im_q[0] <= ent_im;
         for (int i = 1; i < N_DELAY; i++) begin
            dl_re_q[i] <= dl_re_q[i-1];
            dl_im_q[i] <= dl_im_q[i-1];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_real  = out_real_q;
   assign out_imag  = out_imag_q;

endmodule

// File: tb/tb_fft_sdf_bfly.sv
// tb/tb_fft_sdf_bfly.sv - scoreboard bench for fft_sdf_bfly (DW=8, N_DELAY=2, SHIFT=1)
module tb_fft_sdf_bfly;

   localparam int DW = 8;
   localparam int ND = 2;
   localparam int SH = 1;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic signed [64:0] in_real;
   logic signed [64:0] in_imag;
   logic              out_valid;
   logic [DW:0]       out_real;
   logic [DW:0]       out_imag;

   typedef struct {
      bit v;
      int re;
      int im;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   int   m_cnt, m_pend, m_hre, m_him;
   int   m_xre [ND];
   int   m_xim [ND];
   int   m_dre [ND];
   int   m_dim [ND];

   fft_sdf_bfly #(.DW(DW), .N_DELAY(ND), .SHIFT(SH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .out_valid (out_valid),
      .out_real  (out_real),
      .out_imag  (out_imag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int scl(input longint x);
      longint t;
      t = (x + (longint'(1) << (SH - 1))) >>> SH;
`ifdef FFT_SAT_EN
      if (t > 127) t = 127;
      if (t < -128) t = -128;
`else
      t = ((t % 256) + 256) % 256;
      if (t >= 128) t = t - 256;
`endif
      return int'(t);
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_pend = 0;
      m_hre  = 0;
      m_him  = 0;
   endtask

   task automatic model(input bit v, input longint re, input longint im);
      exp_t e;
      int   sr, si, j;
      e.v = 1'b0;
      if (v) begin
         sr = scl(re);
         si = scl(im);
         if (m_cnt < ND) begin
            e.v = (m_pend != 0);
            if (e.v) begin
               m_hre = m_dre[m_cnt];
               m_him = m_dim[m_cnt];
            end
            m_xre[m_cnt] = sr;
            m_xim[m_cnt] = si;
         end else begin
            j = m_cnt - ND;
            e.v = 1'b1;
            m_hre = m_xre[j] + sr;
            m_him = m_xim[j] + si;
            m_dre[j] = m_xre[j] - sr;
            m_dim[j] = m_xim[j] - si;
            if (m_cnt == 2 * ND - 1) m_pend = 1;
         end
         m_cnt = (m_cnt + 1) % (2 * ND);
      end
      e.re = m_hre;
      e.im = m_him;
      sb.push_back(e);
   endtask

   task automatic step(input bit v, input longint re, input longint im);
      exp_t e;
      @(negedge clk);
      in_valid = v;
      in_real  = re;
      in_imag  = im;
      model(v, re, im);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("out_valid", int'(out_valid), int'(e.v));
         check("out_real", int'($signed(out_real)), e.re);
         check("out_imag", int'($signed(out_imag)), e.im);
      end
   endtask

   task automatic frame(input longint a, input longint b, input longint c, input longint d);
      step(1'b1, a, -a);
      step(1'b1, b, -b);
      step(1'b1, c, -c);
      step(1'b1, d, -d);
   endtask

   task automatic gap_frame(input longint a, input longint b, input longint c, input longint d);
      longint v [4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 2)) step(1'b0, 77, -55);
         step(1'b1, v[i], -v[i]);
      end
   endtask

   task automatic check_reset_zero(input string tag);
      check({tag, "_valid"}, int'(out_valid), 0);
      check({tag, "_real"}, int'($signed(out_real)), 0);
      check({tag, "_imag"}, int'($signed(out_imag)), 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_real  = '0;
      in_imag  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_zero("por");
      rst_n = 1'b1;

      // Basic frame then its differences in the following FILL phase.
      frame(2, 4, 6, 8);
      frame(2, 4, 6, 8);
      // Rounding of positive and negative odd values.
      frame(3, -3, 0, 0);
      // Out-of-range scaled values: clamp or wrap depending on build.
      frame(1000, -1000, 0, 0);
      // Extremes of the DW range exercise the extra sum/difference bit.
      frame(254, -256, 254, -256);
      frame(254, -256, -256, 254);
      frame(10, 20, 30, 40);
      // Idle cycles inside frames must not disturb the sequence.
      gap_frame(12, -7, 5, 9);
      gap_frame(-20, 14, 3, -1);
      gap_frame(100, 60, -30, 8);

      // Reset three samples into a frame: partial frame and pending flag discarded.
      step(1'b1, 6, -6);
      step(1'b1, 8, -8);
      step(1'b1, 2, -2);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      model_reset();
      #1;
      check_reset_zero("rst_async");
      @(negedge clk);
      check_reset_zero("rst_hold");
      rst_n = 1'b1;
      frame(4, 2, 8, 6);
      frame(0, 0, 0, 0);
      step(1'b0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_sdf_bfly.md
FFT_SDF_BFLY -- requirements
Module: fft_sdf_bfly

Interface
REQ-001 Parameter DW, default 32: width of the scaled real and imaginary sample inside the butterfly.
REQ-002 Parameter N_DELAY, default 4: delay-line depth (half the butterfly span); power of two, >=1.
REQ-003 Parameter SHIFT, default 16: right-shift applied to the 65-bit products; >=1.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  in_real/in_imag carry a sample this cycle.
REQ-007 in_real  input  65  signed real product from the complex multiplier stage.
REQ-008 in_imag  input  65  signed imaginary product from the complex multiplier stage.
REQ-009 out_valid  output  1  out_real/out_imag are meaningful this cycle.
REQ-010 out_real  output  DW+1  signed butterfly real result.
REQ-011 out_imag  output  DW+1  signed butterfly imaginary result.

Function
REQ-012 Each accepted component SHALL be scaled: s = (x + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift), then reduced to DW bits per REQ-026/027.
REQ-013 An accepted sample (in_valid=1) SHALL advance the frame counter cnt (0..2*N_DELAY-1, wraps to 0) and shift the delay line by one entry (width DW+1 per component).
REQ-014 With in_valid=0, cnt, state, delay line and the pending flag SHALL hold, and out_valid SHALL be 0 next cycle.
REQ-015 FSM states: FILL (cnt<N_DELAY) and BFLY (cnt>=N_DELAY); FILL->BFLY on the accepted sample at cnt=N_DELAY-1; BFLY->FILL on the accepted sample at cnt=2*N_DELAY-1.
REQ-016 FILL: the scaled input, sign-extended, SHALL enter the delay line; the outgoing head value SHALL be emitted.
REQ-017 BFLY: with head a and scaled input b, a+b SHALL be emitted and a-b SHALL enter the delay line.
REQ-018 Outputs SHALL be registered; the result of an accepted sample appears exactly 1 cycle later.
REQ-019 out_valid SHALL be 1 for every BFLY emission, and for FILL emissions only when flag pend=1.
REQ-020 pend SHALL set on the last BFLY sample of a frame and stay set; it SHALL never clear except by reset.
REQ-021 Ordering: frame k sums are emitted during frame k BFLY; frame k differences during frame k+1 FILL; the last frame's differences remain held until further input arrives.
REQ-022 Sum/difference SHALL be computed at DW+1 bits without overflow; out_real/out_imag SHALL hold their value when out_valid=0.

Reset
REQ-023 rst_n low SHALL immediately clear cnt, pend, out_valid, out_real and out_imag to 0 and force state FILL.
REQ-024 Delay-line contents need not be reset; REQ-019 SHALL prevent stale entries from being flagged valid.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first sample after release is frame sample 0.

Configuration
REQ-026 With FFT_SAT_EN defined, a scaled value outside [-2^(DW-1), 2^(DW-1)-1] SHALL clamp to the nearest bound.
REQ-027 Without FFT_SAT_EN, the scaled value SHALL be truncated to its low DW bits (two's-complement wrap).

Structure
REQ-028 Package fft_pkg SHALL hold the DW/SHIFT defaults, the product width constant (65) and the FILL/BFLY state encoding.
REQ-029 Sub-module fft_scale_sat SHALL implement REQ-012/026/027; two instances are used, one per component.

Verification
REQ-030 N_DELAY=2, SHIFT=1, real inputs 2,4,6,8 back-to-back -> out_valid only at BFLY, out_real=4 then 6; next frame inputs -> first two outputs -2,-2 with out_valid=1.
REQ-031 SHIFT=1, in_real=3 -> scaled 2; in_real=-3 -> scaled -1 (checked via a FILL/BFLY pair against 0).
REQ-032 DW=8, SHIFT=1, in_real=1000: with FFT_SAT_EN -> scaled 127; without -> scaled -12.
REQ-033 Random in_valid gaps within a frame -> identical output sequence to gap-free run; out_valid=0 on every idle cycle.
REQ-034 rst_n pulsed low after 3 samples of a frame -> outputs 0 during reset; next frame restarts at cnt=0, no diff outputs until a full BFLY phase completes.
